// File: rtl/mul_datapath.sv
// Add-shift datapath for the sequenced shift-add multiplier.
// Executes Load / Ad / Sh commands from the controller and reports the
// current multiplier bit (M) and the last-shift flag (K) back to it.
// The finished 2N-bit product is held with a valid flag until the next
// Load or reset.
module mul_datapath #(
    parameter int N  = 4,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Load,
    input  logic           Sh,
    input  logic           Ad,
    input  logic [N-1:0]   Mcand,
    input  logic [N-1:0]   Mplier,
    output logic           M,
    output logic           K,
    output logic [2*N-1:0] Product,
    output logic           PValid
);

    // acc_q[2N] catches the add carry; it is always shifted out again
    // before the result completes.
    logic [2*N:0]   acc_q,    acc_d;
    logic [N-1:0]   mcr_q,    mcr_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic           pvalid_q, pvalid_d;

    logic           last_shift;
    logic [N:0]     sum;
    logic [2*N:0]   added;

    assign last_shift = (cnt_q == CW'(N - 1));

    // Next-state computation: Load has priority, then add and/or shift.
    always_comb begin
        acc_d    = acc_q;
        mcr_d    = mcr_q;
        cnt_d    = cnt_q;
        pvalid_d = pvalid_q;
        sum      = {1'b0, acc_q[2*N-1:N]} + {1'b0, mcr_q};
        added    = Ad ? {sum, acc_q[N-1:0]} : acc_q;

        if (Load) begin
            acc_d    = {{(N+1){1'b0}}, Mplier};
            mcr_d    = Mcand;
            cnt_d    = '0;
            pvalid_d = 1'b0;
        end else if (Sh) begin
            // A combined Ad+Sh shifts the freshly added value.
            acc_d    = {1'b0, added[2*N:1]};
            cnt_d    = last_shift ? '0 : cnt_q + CW'(1);
            pvalid_d = pvalid_q | last_shift;
        end else if (Ad) begin
            acc_d    = added;
        end
    end

    // State registers; reset abandons any multiply in progress.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc_q    <= '0;
            mcr_q    <= '0;
            cnt_q    <= '0;
            pvalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcr_q    <= mcr_d;
            cnt_q    <= cnt_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign M       = acc_q[0];
    assign K       = last_shift;
    assign Product = acc_q[2*N-1:0];
    assign PValid  = pvalid_q;

endmodule
